// File: rtl/dram_rst_sequencer_if.sv
// Handshake/status bundle between the DDR3 reset sequencer and its surroundings.
// The slave side is the sequencer. The master side is the DRAM wrapper, GPIO and debug.
interface dram_rst_sequencer_if #(
   parameter int RW = 2
);
   logic          i_init_calib_complete;
   logic          i_soft_rst;
   logic          o_sys_rst;
   logic          o_calib_done;
   logic          o_fail;
   logic [RW-1:0] o_retry_cnt;
   logic [2:0]    o_state;

   modport master (
      output i_init_calib_complete,
      output i_soft_rst,
      input  o_sys_rst,
      input  o_calib_done,
      input  o_fail,
      input  o_retry_cnt,
      input  o_state
   );

   modport slave (
      input  i_init_calib_complete,
      input  i_soft_rst,
      output o_sys_rst,
      output o_calib_done,
      output o_fail,
      output o_retry_cnt,
      output o_state
   );
endinterface

// File: rtl/dram_rst_sequencer.sv
// DDR3 reset/calibration sequencer: holds sys_rst for a minimum time and watches calibration.
// It retries a bounded number of times, then latches a sticky failure flag.
module dram_rst_sequencer #(
   parameter int HOLD_CYCLES   = 16,
   parameter int CALIB_TIMEOUT = 33_334_000,
   parameter int MAX_RETRY     = 3,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                  clk_166_67_mhz,
   input  logic                  dram_rstx_async,
   dram_rst_sequencer_if.slave   bus
);
   localparam int RW      = $clog2(MAX_RETRY + 1);
   localparam int CNT_MAX = (HOLD_CYCLES > CALIB_TIMEOUT) ? HOLD_CYCLES : CALIB_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX);

   typedef enum logic [1:0] {
      ST_HOLD       = 2'd0,
      ST_WAIT_CALIB = 2'd1,
      ST_RUN        = 2'd2,
      ST_FAIL       = 2'd3
   } state_t;

   logic [1:0]             rst_sync_q;
   logic                   rst_i;
   logic [SYNC_STAGES-1:0] calib_sync_q;
   logic                   calib_s;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          sys_rst_q, calib_done_q, fail_q;
   logic [2:0]    state_out_q;

   // Reset assertion is immediate; release is synchronised to the clock.
   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) rst_sync_q <= 2'b11;
      else                  rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_i = rst_sync_q[1];

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_calib_sync
         always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
            if (!dram_rstx_async) calib_sync_q[gi] <= 1'b0;
            else if (gi == 0)     calib_sync_q[gi] <= bus.i_init_calib_complete;
            else                  calib_sync_q[gi] <= calib_sync_q[(gi == 0) ? 0 : gi-1];
         end
      end
   endgenerate
   assign calib_s = calib_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_q;
      if (bus.i_soft_rst) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                  state_d = ST_WAIT_CALIB;
                  cnt_d   = '0;
               end
            end
            ST_WAIT_CALIB: begin
               // Calibration seen in the timeout cycle still wins.
               if (calib_s) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else if (cnt_q == CW'(CALIB_TIMEOUT - 1)) begin
                  cnt_d = '0;
                  if (retry_q == RW'(MAX_RETRY)) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d = ST_HOLD;
                     retry_d = retry_q + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               cnt_d = '0;
               if (!calib_s) begin
                  if (retry_q == RW'(MAX_RETRY)) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d = ST_HOLD;
                     retry_d = retry_q + 1'b1;
                  end
               end
            end
            default: cnt_d = '0;
         endcase
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as the state.
   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         state_q      <= ST_HOLD;
         cnt_q        <= '0;
         retry_q      <= '0;
         sys_rst_q    <= 1'b1;
         calib_done_q <= 1'b0;
         fail_q       <= 1'b0;
         state_out_q  <= 3'd0;
      end else if (rst_i) begin
         state_q      <= ST_HOLD;
         cnt_q        <= '0;
         retry_q      <= '0;
         sys_rst_q    <= 1'b1;
         calib_done_q <= 1'b0;
         fail_q       <= 1'b0;
         state_out_q  <= 3'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         sys_rst_q    <= (state_d == ST_HOLD) || (state_d == ST_FAIL);
         calib_done_q <= (state_d == ST_RUN);
         fail_q       <= (state_d == ST_FAIL);
         state_out_q  <= {1'b0, state_d};
      end
   end

   assign bus.o_sys_rst    = sys_rst_q;
   assign bus.o_calib_done = calib_done_q;
   assign bus.o_fail       = fail_q;
   assign bus.o_retry_cnt  = retry_q;
   assign bus.o_state      = state_out_q;
endmodule

// File: tb/tb_dram_rst_sequencer.sv
// Randomised self-checking bench for dram_rst_sequencer.
// Expected behaviour comes from edge arithmetic derived from the sequencing rules.
`timescale 1ns/1ps
module tb_dram_rst_sequencer;
   localparam int HOLD = 16;
   localparam int TO   = 100;
   localparam int MR   = 2;
   localparam int SS   = 2;
   localparam int P    = HOLD + TO;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;

   always #3 clk = ~clk;

   dram_rst_sequencer_if #(.RW(2)) bus ();

   dram_rst_sequencer #(
      .HOLD_CYCLES   (HOLD),
      .CALIB_TIMEOUT (TO),
      .MAX_RETRY     (MR),
      .SYNC_STAGES   (SS)
   ) dut (
      .clk_166_67_mhz  (clk),
      .dram_rstx_async (rstn),
      .bus             (bus)
   );

   task automatic tick();
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic release_reset();
      bus.i_init_calib_complete = 1'b0;
      bus.i_soft_rst            = 1'b0;
      rstn                      = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rstn   = 1'b1;
      edge_n = 0;
   endtask

   // Expected state and retry count with calibration never arriving.
   function automatic void model_nocalib(input int e, output int st, output int rc);
      int t, k;
      if (e < 2) begin
         st = 0; rc = 0;
         return;
      end
      t = e - 2;
      k = t / P;
      if (k > MR) begin
         st = 3; rc = MR;
      end else begin
         rc = k;
         st = ((t % P) < HOLD) ? 0 : 1;
      end
   endfunction

   task automatic test_reset();
      bus.i_init_calib_complete = 1'b0;
      bus.i_soft_rst            = 1'b0;
      rstn = 1'b0;
      #10;
      n_checks++;
      if (bus.o_sys_rst !== 1'b1 || bus.o_calib_done !== 1'b0 || bus.o_fail !== 1'b0 ||
          bus.o_retry_cnt !== 2'd0 || bus.o_state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_values: got rst=%b done=%b fail=%b retry=%0d state=%0d, expected 1 0 0 0 0",
                  bus.o_sys_rst, bus.o_calib_done, bus.o_fail, bus.o_retry_cnt, bus.o_state);
      end
      release_reset();
      repeat (2) tick();
      n_checks++;
      if (bus.o_sys_rst !== 1'b1 || bus.o_state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_release_edge2: got rst=%b state=%0d, expected 1 0", bus.o_sys_rst, bus.o_state);
      end
      $display("test_reset done");
   endtask

   // Calibration raised just after edge r; the FSM sees it 3 edges later, but not before WAIT_CALIB.
   task automatic test_calib(input int r);
      int e_done, exp_st;
      logic exp_rst, exp_done;
      release_reset();
      e_done = (r + 3 > HOLD + 3) ? r + 3 : HOLD + 3;
      while (edge_n < e_done + 4) begin
         tick();
         if (edge_n == r) bus.i_init_calib_complete = 1'b1;
         exp_rst  = (edge_n < HOLD + 2);
         exp_done = (edge_n >= e_done);
         exp_st   = exp_done ? 2 : (edge_n >= HOLD + 2 ? 1 : 0);
         n_checks++;
         if (bus.o_sys_rst !== exp_rst) begin
            n_fail++;
            $display("FAIL calib_sys_rst edge %0d: got %b expected %b", edge_n, bus.o_sys_rst, exp_rst);
         end
         n_checks++;
         if (bus.o_calib_done !== exp_done) begin
            n_fail++;
            $display("FAIL calib_done edge %0d: got %b expected %b", edge_n, bus.o_calib_done, exp_done);
         end
         n_checks++;
         if (bus.o_state !== 3'(exp_st) || bus.o_retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL calib_state edge %0d: got state=%0d retry=%0d expected %0d 0",
                     edge_n, bus.o_state, bus.o_retry_cnt, exp_st);
         end
      end
      $display("test_calib raise=%0d done_edge=%0d", r, e_done);
   endtask

   // Starts in RUN with calibration high and no retries consumed.
   task automatic test_calib_loss();
      int l, rr, e_wait, e_done;
      logic exp_rst, exp_done;
      repeat ($urandom_range(1, 20)) tick();
      bus.i_init_calib_complete = 1'b0;
      l = edge_n;
      repeat (2) tick();
      n_checks++;
      if (bus.o_calib_done !== 1'b1 || bus.o_sys_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL loss_early edge %0d: got done=%b rst=%b expected 1 0", edge_n, bus.o_calib_done, bus.o_sys_rst);
      end
      tick();
      n_checks++;
      if (bus.o_calib_done !== 1'b0 || bus.o_sys_rst !== 1'b1 || bus.o_retry_cnt !== 2'd1 || bus.o_state !== 3'd0) begin
         n_fail++;
         $display("FAIL loss_detect edge %0d: got done=%b rst=%b retry=%0d state=%0d expected 0 1 1 0",
                  edge_n, bus.o_calib_done, bus.o_sys_rst, bus.o_retry_cnt, bus.o_state);
      end
      repeat ($urandom_range(0, 30)) tick();
      bus.i_init_calib_complete = 1'b1;
      rr     = edge_n;
      e_wait = l + 3 + HOLD;
      e_done = (rr + 3 > e_wait + 1) ? rr + 3 : e_wait + 1;
      while (edge_n < e_done + 2) begin
         tick();
         exp_rst  = (edge_n < e_wait);
         exp_done = (edge_n >= e_done);
         n_checks++;
         if (bus.o_sys_rst !== exp_rst || bus.o_calib_done !== exp_done || bus.o_retry_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL loss_recover edge %0d: got rst=%b done=%b retry=%0d expected %b %b 1",
                     edge_n, bus.o_sys_rst, bus.o_calib_done, bus.o_retry_cnt, exp_rst, exp_done);
         end
      end
      $display("test_calib_loss drop=%0d reraise=%0d done_edge=%0d", l, rr, e_done);
   endtask

   task automatic test_same_cycle();
      test_calib(HOLD + 2 + TO - 3);
      n_checks++;
      if (bus.o_state !== 3'd2 || bus.o_retry_cnt !== 2'd0 || bus.o_fail !== 1'b0) begin
         n_fail++;
         $display("FAIL same_cycle: got state=%0d retry=%0d fail=%b expected 2 0 0",
                  bus.o_state, bus.o_retry_cnt, bus.o_fail);
      end
      $display("test_same_cycle done");
   endtask

   task automatic test_retry_fail();
      int st, rc;
      release_reset();
      while (edge_n < 2 + 3 * P + 10) begin
         tick();
         model_nocalib(edge_n, st, rc);
         n_checks++;
         if (bus.o_state !== 3'(st) || bus.o_retry_cnt !== 2'(rc) || bus.o_fail !== (st == 3) ||
             bus.o_sys_rst !== (st == 0 || st == 3) || bus.o_calib_done !== 1'b0) begin
            n_fail++;
            $display("FAIL retry edge %0d: got state=%0d retry=%0d fail=%b rst=%b expected state=%0d retry=%0d",
                     edge_n, bus.o_state, bus.o_retry_cnt, bus.o_fail, bus.o_sys_rst, st, rc);
         end
      end
      $display("test_retry_fail reached edge %0d", edge_n);
   endtask

   // Starts in FAIL; soft restart of random length.
   task automatic test_soft_rst();
      int len;
      len = $urandom_range(1, 3);
      bus.i_soft_rst = 1'b1;
      repeat (len) begin
         tick();
         n_checks++;
         if (bus.o_state !== 3'd0 || bus.o_fail !== 1'b0 || bus.o_retry_cnt !== 2'd0 || bus.o_sys_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL soft_rst_hold edge %0d: got state=%0d fail=%b retry=%0d rst=%b expected 0 0 0 1",
                     edge_n, bus.o_state, bus.o_fail, bus.o_retry_cnt, bus.o_sys_rst);
         end
      end
      bus.i_soft_rst = 1'b0;
      for (int i = 1; i <= HOLD; i++) begin
         tick();
         n_checks++;
         if (bus.o_sys_rst !== (i < HOLD) || bus.o_state !== ((i < HOLD) ? 3'd0 : 3'd1)) begin
            n_fail++;
            $display("FAIL soft_rst_release +%0d: got rst=%b state=%0d expected rst=%b", i, bus.o_sys_rst,
                     bus.o_state, (i < HOLD));
         end
      end
      $display("test_soft_rst len=%0d", len);
   endtask

   // Starts in WAIT_CALIB after a soft restart.
   task automatic test_async_reset();
      repeat ($urandom_range(1, 50)) tick();
      bus.i_init_calib_complete = 1'b0;
      #1;
      rstn = 1'b0;
      #0.5;
      n_checks++;
      if (bus.o_sys_rst !== 1'b1 || bus.o_calib_done !== 1'b0 || bus.o_fail !== 1'b0 ||
          bus.o_retry_cnt !== 2'd0 || bus.o_state !== 3'd0) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got rst=%b done=%b fail=%b retry=%0d state=%0d expected 1 0 0 0 0",
                  bus.o_sys_rst, bus.o_calib_done, bus.o_fail, bus.o_retry_cnt, bus.o_state);
      end
      release_reset();
      repeat (HOLD + 1) tick();
      n_checks++;
      if (bus.o_sys_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL async_rerelease edge %0d: got rst=%b expected 1", edge_n, bus.o_sys_rst);
      end
      tick();
      n_checks++;
      if (bus.o_sys_rst !== 1'b0 || bus.o_state !== 3'd1) begin
         n_fail++;
         $display("FAIL async_rerelease edge %0d: got rst=%b state=%0d expected 0 1", edge_n, bus.o_sys_rst, bus.o_state);
      end
      $display("test_async_reset done");
   endtask

   initial begin
      bus.i_init_calib_complete = 1'b0;
      bus.i_soft_rst            = 1'b0;
      test_reset();
      test_calib(40);
      test_calib_loss();
      test_calib($urandom_range(5, 112));
      test_calib_loss();
      test_same_cycle();
      test_retry_fail();
      test_soft_rst();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dram_rst_sequencer.md
# dram_rst_sequencer

Reset and calibration sequencer for the DDR3 controller, sitting directly upstream of the DRAM wrapper's `sys_rst` input in the 166.67 MHz system-clock domain. Replaces the bare two-flop release synchroniser: it holds the controller in reset for a guaranteed minimum time and watches `init_calib_complete`. If calibration does not arrive, or is lost, it re-runs the reset/calibration sequence a bounded number of times, then latches a failure flag. It also exposes status for GPIO and debug.

## Interface
Parameters:
- HOLD_CYCLES, 16: minimum `o_sys_rst` assertion per attempt, in cycles (≥2).
- CALIB_TIMEOUT, 33_334_000: cycles to wait for calibration per attempt (200 ms); ≥2.
- MAX_RETRY, 3: re-attempts after the first; width RW = $clog2(MAX_RETRY+1).
- SYNC_STAGES, 2: synchroniser depth for `i_init_calib_complete` (≥2).

Ports:
- clk_166_67_mhz  in  1  system clock; all state is on the rising edge.
- dram_rstx_async  in  1  asynchronous, active-low reset (`resetn & locked`).
- i_init_calib_complete  in  1  from the DRAM wrapper; asynchronous to this clock; synchronised internally.
- i_soft_rst  in  1  synchronous restart request, level-sensitive.
- o_sys_rst  out  1  active-high reset to the DRAM `sys_rst`; registered.
- o_calib_done  out  1  calibration achieved and held; registered.
- o_fail  out  1  retries exhausted; registered, sticky.
- o_retry_cnt  out  RW  re-attempts consumed; saturates at MAX_RETRY.
- o_state  out  3  encoded FSM state for debug: HOLD=0, WAIT_CALIB=1, RUN=2, FAIL=3.

## Operation
- Reset release synchroniser:
  - Two flops, asynchronously set to 1 by `dram_rstx_async` low, shifting in 0.
  - Internal reset `rst_i` is their output.
  - `rst_i` holds FSM, counter and outputs in reset values.
- Reset values:
  - State HOLD, counter 0, `o_sys_rst`=1, `o_calib_done`=0, `o_fail`=0, `o_retry_cnt`=0, `o_state`=0.
  - Calibration synchroniser flops 0.
- Counter: width $clog2(max(HOLD_CYCLES, CALIB_TIMEOUT)); cleared on every state entry.
- HOLD:
  - `o_sys_rst`=1; counter increments each cycle.
  - When counter == HOLD_CYCLES-1: go to WAIT_CALIB.
- WAIT_CALIB:
  - `o_sys_rst`=0; counter increments each cycle.
  - If synchronised calib = 1: go to RUN.
  - Else if counter == CALIB_TIMEOUT-1:
    - If `o_retry_cnt` == MAX_RETRY: go to FAIL.
    - Otherwise: `o_retry_cnt`+1 and go to HOLD.
- RUN:
  - `o_calib_done`=1, `o_sys_rst`=0.
  - If synchronised calib = 0: apply the same retry decision as a timeout (increment and go to HOLD, or go to FAIL).
- FAIL:
  - `o_sys_rst`=1, `o_fail`=1.
  - Terminal until `i_soft_rst` or async reset.
- `i_soft_rst`=1 in any state (synchronous) restarts the sequence:
  - Next state HOLD, counter 0.
  - `o_retry_cnt`, `o_fail` and `o_calib_done` cleared; `o_sys_rst`=1.
  - While the request is held, the FSM stays in HOLD with counter 0.
- Outputs are registered from the next-state value, so they change on the same edge as the state; no combinational outputs.

## Timing
- Reset release: edges numbered from the first rising edge after `dram_rstx_async` rises.
  - `rst_i` falls after edge 2.
  - `o_sys_rst` falls on edge 2+HOLD_CYCLES.
- Calibration latency: from `i_init_calib_complete` rising (setup met) to `o_calib_done` rising is SYNC_STAGES+1 edges. Loss of calibration to `o_calib_done` falling and `o_sys_rst` rising is the same.
- Per-attempt period without calibration: HOLD_CYCLES + CALIB_TIMEOUT cycles.
- Simultaneous events, in priority order:
  - Async reset.
  - `i_soft_rst`.
  - Calibration seen in WAIT_CALIB (beats a timeout in the same cycle).
  - Timeout.
- Async reset mid-sequence: all outputs take their reset values immediately, without waiting for a clock edge. The full sequence repeats after release.
- Glitches on calibration shorter than one clock period may be missed; this is acceptable.

## Test plan
Bench parameters: HOLD_CYCLES=16, CALIB_TIMEOUT=100, MAX_RETRY=2, SYNC_STAGES=2.
- Release reset, raise calib at edge 40 → `o_sys_rst` falls at edge 18; `o_calib_done` rises at edge 43; `o_state`=2; `o_retry_cnt`=0.
- Calib held 0 → `o_sys_rst` re-asserts at edges 118 and 234 (`o_retry_cnt` 1, then 2); FAIL at edge 350 with `o_fail`=1, `o_sys_rst`=1, `o_state`=3; state stays there.
- In RUN, drop calib → 3 edges later `o_calib_done`=0, `o_sys_rst`=1, `o_retry_cnt`=1; re-raise calib → RUN again.
- Calib arrives in the same cycle as the timeout → RUN, `o_retry_cnt` unchanged.
- `i_soft_rst` pulse for 1 cycle in FAIL → next edge: HOLD, `o_fail`=0, `o_retry_cnt`=0; `o_sys_rst` falls 16 edges later.
- Pull `dram_rstx_async` low mid-WAIT_CALIB → outputs take reset values immediately; after release, `o_sys_rst` falls at edge 18.
